mem_port_arbiter: RTL and testbench

//  Shares one single-ported synchronous memory between the IF requester (instruction

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous single-ported memory between the IF and MEM requesters.
// Optional fairness (IF granted after FAIR_LIMIT consecutive D grants) is built when MEM_ARB_FAIR_EN is defined.
module mem_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_sel,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_sel,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD_IF = 2'd1;
  localparam logic [1:0] S_RD_D  = 2'd2;
  localparam logic [2:0] LAT     = 3'(RD_LAT);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_if_rvalid;
  logic        r_d_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        w_idle;
  logic        w_fair_force;
  logic        w_if_gnt;
  logic        w_d_gnt;

  // Grants only in IDLE and never while reset is asserted.
  assign w_idle = resetn && (r_state == S_IDLE);

`ifdef MEM_ARB_FAIR_EN
  logic [2:0] r_fair_cnt;

  assign w_fair_force = (r_fair_cnt == 3'(FAIR_LIMIT)) && i_if_req && i_d_req;

  always_ff @(posedge clk) begin
    if (!resetn)
      r_fair_cnt <= 3'd0;
    else if (!i_if_req || w_if_gnt)
      r_fair_cnt <= 3'd0;
    else if (w_d_gnt)
      r_fair_cnt <= r_fair_cnt + 3'd1;
  end
`else
  assign w_fair_force = 1'b0;
`endif

  assign w_d_gnt  = w_idle && i_d_req && !w_fair_force;
  assign w_if_gnt = w_idle && i_if_req && (!i_d_req || w_fair_force);

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_mem_sel   = 4'h0;
    if (w_d_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_d_we;
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_we ? i_d_wdata : 32'h0;
      o_mem_sel   = i_d_we ? i_d_sel : 4'hF;
    end else if (w_if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_if_addr;
      o_mem_sel  = 4'hF;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= 32'h0;
      r_d_rdata   <= 32'h0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_d_gnt && !i_d_we) begin
            r_state <= S_RD_D;
            r_cnt   <= 3'd1;
          end else if (w_if_gnt) begin
            r_state <= S_RD_IF;
            r_cnt   <= 3'd1;
          end
        end
        S_RD_IF, S_RD_D: begin
          if (r_cnt >= LAT) begin
            // Last latency cycle: capture now, pulse rvalid in the following IDLE cycle.
            if (r_state == S_RD_IF) begin
              r_if_rdata  <= i_mem_rdata;
              r_if_rvalid <= 1'b1;
            end else begin
              r_d_rdata  <= i_mem_rdata;
              r_d_rvalid <= 1'b1;
            end
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  assign o_if_gnt    = w_if_gnt;
  assign o_d_gnt     = w_d_gnt;
  assign o_if_rvalid = r_if_rvalid;
  assign o_d_rvalid  = r_d_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with RD_LAT=2 and a behavioural 2-cycle memory.
// Fairness expectations switch on MEM_ARB_FAIR_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_d_req;
  logic        i_d_we;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_sel;
  logic        o_d_gnt;
  logic        o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_sel;
  logic [31:0] i_mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LAT(2), .FAIR_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_sel(i_d_sel), .o_d_gnt(o_d_gnt),
    .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_sel(o_mem_sel), .i_mem_rdata(i_mem_rdata)
  );

  // Memory model: 256 words, read data visible two cycles after the access cycle.
  logic [31:0] mem [0:255];
  logic [31:0] p0, p1;
  assign i_mem_rdata = p1;

  always @(posedge clk) begin
    if (o_mem_en && o_mem_we) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_sel[b]) mem[o_mem_addr[9:2]][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
    end
    p0 <= (o_mem_en && !o_mem_we) ? mem[o_mem_addr[9:2]] : 32'h0;
    p1 <= p0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_if_req = 0; i_if_addr = 0;
    i_d_req = 0; i_d_we = 0; i_d_addr = 0; i_d_wdata = 0; i_d_sel = 0;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata;
    logic        e_if_rv;
    logic        e_d_rv;
    logic [31:0] e_if_rd;
    logic [31:0] e_d_rd;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] ds,
    input logic eig, input logic edg, input logic een, input logic ewe,
    input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ewd,
    input logic eirv, input logic edrv, input logic [31:0] eird, input logic [31:0] edrd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd; v.d_sel = ds;
    v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_en = een; v.e_we = ewe;
    v.e_addr = ea; v.e_sel = es; v.e_wdata = ewd;
    v.e_if_rv = eirv; v.e_d_rv = edrv; v.e_if_rd = eird; v.e_d_rd = edrd;
    return v;
  endfunction

  vec_t vecs [13];
  int   n_dg, n_ig, rv_seen, first_ig;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'hAAAA_BBBB;  // 0x040
    mem[64] = 32'hDEAD_BEEF;  // 0x100
    mem[65] = 32'hCAFE_F00D;  // 0x104
    mem[66] = 32'h1111_2222;  // 0x108
    mem[67] = 32'h3333_4444;  // 0x10C
    p0 = 0; p1 = 0;

    //           if_req/addr   d_req we addr   wdata          sel    | ifg dg en we addr   sel   wdata          ifrv drv if_rd          d_rd
    vecs[0]  = mk(1, 32'h100,  1, 1, 32'h40,  32'h1234_5678, 4'h3,   0, 1, 1, 1, 32'h40,  4'h3, 32'h1234_5678, 0, 0, 32'h0,          32'h0);
    vecs[1]  = mk(1, 32'h100,  0, 0, 32'h0,   32'h0,         4'h0,   1, 0, 1, 0, 32'h100, 4'hF, 32'h0,         0, 0, 32'h0,          32'h0);
    vecs[2]  = mk(0, 32'h0,    1, 0, 32'h104, 32'h0,         4'h0,   0, 0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0, 32'h0,          32'h0);
    vecs[3]  = mk(0, 32'h0,    1, 0, 32'h104, 32'h0,         4'h0,   0, 0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0, 32'h0,          32'h0);
    vecs[4]  = mk(0, 32'h0,    1, 0, 32'h104, 32'h0,         4'h0,   0, 1, 1, 0, 32'h104, 4'hF, 32'h0,         1, 0, 32'hDEAD_BEEF, 32'h0);
    vecs[5]  = mk(1, 32'h200,  0, 0, 32'h0,   32'h0,         4'h0,   0, 0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0, 32'hDEAD_BEEF, 32'h0);
    vecs[6]  = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         4'h0,   0, 0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0, 32'hDEAD_BEEF, 32'h0);
    vecs[7]  = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         4'h0,   0, 0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    vecs[8]  = mk(1, 32'h40,   0, 0, 32'h0,   32'h0,         4'h0,   1, 0, 1, 0, 32'h40,  4'hF, 32'h0,         0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    vecs[9]  = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         4'h0,   0, 0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    vecs[10] = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         4'h0,   0, 0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    vecs[11] = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         4'h0,   0, 0, 0, 0, 32'h0,   4'h0, 32'h0,         1, 0, 32'hAAAA_5678, 32'hCAFE_F00D);
    vecs[12] = mk(0, 32'h0,    0, 0, 32'h0,   32'h0,         4'h0,   0, 0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0, 32'hAAAA_5678, 32'hCAFE_F00D);

    // Reset held with both requests active.
    resetn = 0;
    idle_inputs();
    i_if_req = 1; i_if_addr = 32'h100; i_d_req = 1; i_d_addr = 32'h104;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst if_gnt", {31'b0, o_if_gnt}, 32'h0);
    check("rst d_gnt", {31'b0, o_d_gnt}, 32'h0);
    check("rst mem_en", {31'b0, o_mem_en}, 32'h0);
    check("rst mem_we", {31'b0, o_mem_we}, 32'h0);
    check("rst rvalids", {30'b0, o_if_rvalid, o_d_rvalid}, 32'h0);
    check("rst if_rdata", o_if_rdata, 32'h0);
    check("rst d_rdata", o_d_rdata, 32'h0);
    next_cycle();
    resetn = 1;
    idle_inputs();

    // Cycle-accurate table: store, IF read, D load, dropped request, store readback.
    for (int i = 0; i < 13; i++) begin
      i_if_req = vecs[i].if_req; i_if_addr = vecs[i].if_addr;
      i_d_req = vecs[i].d_req; i_d_we = vecs[i].d_we; i_d_addr = vecs[i].d_addr;
      i_d_wdata = vecs[i].d_wdata; i_d_sel = vecs[i].d_sel;
      @(negedge clk);
      check($sformatf("v%0d if_gnt", i), {31'b0, o_if_gnt}, {31'b0, vecs[i].e_if_gnt});
      check($sformatf("v%0d d_gnt", i), {31'b0, o_d_gnt}, {31'b0, vecs[i].e_d_gnt});
      check($sformatf("v%0d mem_en", i), {31'b0, o_mem_en}, {31'b0, vecs[i].e_en});
      check($sformatf("v%0d mem_we", i), {31'b0, o_mem_we}, {31'b0, vecs[i].e_we});
      check($sformatf("v%0d mem_addr", i), o_mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d mem_sel", i), {28'b0, o_mem_sel}, {28'b0, vecs[i].e_sel});
      check($sformatf("v%0d mem_wdata", i), o_mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d if_rvalid", i), {31'b0, o_if_rvalid}, {31'b0, vecs[i].e_if_rv});
      check($sformatf("v%0d d_rvalid", i), {31'b0, o_d_rvalid}, {31'b0, vecs[i].e_d_rv});
      check($sformatf("v%0d if_rdata", i), o_if_rdata, vecs[i].e_if_rd);
      check($sformatf("v%0d d_rdata", i), o_d_rdata, vecs[i].e_d_rd);
      next_cycle();
    end

    // Collision: D load wins, IF is granted in D's rvalid cycle.
    i_if_req = 1; i_if_addr = 32'h10C;
    i_d_req = 1; i_d_we = 0; i_d_addr = 32'h108;
    @(negedge clk);
    check("col d_gnt", {31'b0, o_d_gnt}, 32'h1);
    check("col if_gnt T", {31'b0, o_if_gnt}, 32'h0);
    next_cycle();
    i_d_req = 0;
    n_ig = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_ig += int'(o_if_gnt);
      next_cycle();
    end
    check("col if_gnt in flight", n_ig, 0);
    @(negedge clk);
    check("col d_rvalid", {31'b0, o_d_rvalid}, 32'h1);
    check("col d_rdata", o_d_rdata, 32'h1111_2222);
    check("col if_gnt T+3", {31'b0, o_if_gnt}, 32'h1);
    check("col if addr", o_mem_addr, 32'h10C);
    next_cycle();
    i_if_req = 0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("col if_rvalid", {31'b0, o_if_rvalid}, 32'h1);
    check("col if_rdata", o_if_rdata, 32'h3333_4444);
    next_cycle();

    // Reset asserted one cycle into an IF read: result must be dropped.
    i_if_req = 1; i_if_addr = 32'h100;
    @(negedge clk);
    check("mid if_gnt", {31'b0, o_if_gnt}, 32'h1);
    next_cycle();
    i_if_req = 0;
    resetn = 0;
    next_cycle();
    resetn = 1;
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rv_seen += int'(o_if_rvalid);
      next_cycle();
    end
    check("mid no rvalid", rv_seen, 0);
    check("mid rdata cleared", o_if_rdata, 32'h0);
    i_if_req = 1; i_if_addr = 32'h104;
    @(negedge clk);
    check("mid regrant", {31'b0, o_if_gnt}, 32'h1);
    next_cycle();
    i_if_req = 0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("mid post rvalid", {31'b0, o_if_rvalid}, 32'h1);
    check("mid post rdata", o_if_rdata, 32'hCAFE_F00D);
    next_cycle();

    // Stores every cycle with IF held: fairness decides whether IF ever wins.
    i_if_req = 1; i_if_addr = 32'h100;
    i_d_req = 1; i_d_we = 1; i_d_addr = 32'h80; i_d_wdata = 32'h5555_AAAA; i_d_sel = 4'hF;
    n_dg = 0; n_ig = 0; first_ig = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_dg += int'(o_d_gnt);
      if (o_if_gnt) begin
        n_ig++;
        if (first_ig < 0) first_ig = c;
      end
      next_cycle();
      if (n_ig != 0) break;
    end
    idle_inputs();
`ifdef MEM_ARB_FAIR_EN
    check("fair d grants", n_dg, 4);
    check("fair if cycle", first_ig, 4);
`else
    check("strict d grants", n_dg, 8);
    check("strict if grants", n_ig, 0);
`endif
    repeat (4) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
